// File: rtl/forward_scoreboard_pkg.sv
// forward_scoreboard_pkg: shared stage-entry type and sizing helpers for the bypass scoreboard (package forward_pkg).
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
package forward_pkg;
    localparam int MAX_ADDR_W = `REG_ADDR_W;
    localparam int MAX_EW_LAYER = 13;
    function automatic int NSTG_OF(input int ew_layer);
        return ew_layer + 2;
    endfunction
    // Wide enough for the deepest supported pipeline so one struct fits every build
    localparam int RDY_STG_W = $clog2(NSTG_OF(MAX_EW_LAYER) + 1);
    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] addr;
        logic                  to_g;
        logic                  to_f;
        logic [RDY_STG_W-1:0]  rdy_stg;
    } stage_entry_t;
endpackage

// File: rtl/forward_scoreboard_match_cell.sv
// fwd_match_cell: compares one source operand against one tracked stage entry.
module fwd_match_cell
    import forward_pkg::*;
#(
    parameter int REG_ADDR_W = MAX_ADDR_W,
    parameter int STG        = 0,
    parameter bit ZERO_REG_G = 1'b1
) (
    input  stage_entry_t          entry,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_g,
    input  logic                  src_f,
    input  logic                  dec_valid,
    output logic                  match,
    output logic                  ready
);
    logic addr_eq, g_hit, f_hit;
    assign addr_eq = entry.addr == MAX_ADDR_W'(src_addr);
    // The zero register only masks the GPR path; an FPR at address 0 is real
    assign g_hit = src_g & entry.to_g & ~(ZERO_REG_G && entry.addr == '0);
    assign f_hit = src_f & entry.to_f;
    assign match = dec_valid & entry.valid & addr_eq & (g_hit | f_hit);
    assign ready = entry.rdy_stg <= RDY_STG_W'(STG);
endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: operand bypass select and load-use stall between decode and execute.
// Define FWD_SCOREBOARD_STATS_EN to add saturating stall/forward statistics counters.
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter int  NUM_SRC    = 3,
    parameter int  EW_LAYER   = 1,
    parameter int  REG_ADDR_W = MAX_ADDR_W,
    parameter bit  ZERO_REG_G = 1'b1,
    localparam int NSTG       = NSTG_OF(EW_LAYER),
    localparam int SW         = $clog2(NSTG + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                dec_valid,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] dec_src_addr,
    input  logic [NUM_SRC-1:0]                  dec_src_g,
    input  logic [NUM_SRC-1:0]                  dec_src_f,
    input  logic [REG_ADDR_W-1:0]               dec_dst_addr,
    input  logic                                dec_dst_g,
    input  logic                                dec_dst_f,
    input  logic [SW-1:0]                       dec_rdy_stg,
    output logic [NUM_SRC-1:0]                  fwd_hit,
    output logic [NUM_SRC-1:0][NSTG-1:0]        fwd_sel,
    output logic                                stall
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    input  logic                                stat_clr,
    output logic [31:0]                         stat_stall_cyc,
    output logic [31:0]                         stat_fwd_cnt
`endif
);
    stage_entry_t stg [NSTG];
    stage_entry_t dec_entry;
    logic [NUM_SRC-1:0][NSTG-1:0] m, r;
    logic [NUM_SRC-1:0] blk;
    // Gating the match with rst forces every output low while reset is held
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        for (genvar k = 0; k < NSTG; k++) begin : g_stg
            fwd_match_cell #(
                .REG_ADDR_W(REG_ADDR_W),
                .STG       (k),
                .ZERO_REG_G(ZERO_REG_G)
            ) u_cell (
                .entry    (stg[k]),
                .src_addr (dec_src_addr[i]),
                .src_g    (dec_src_g[i]),
                .src_f    (dec_src_f[i]),
                .dec_valid(dec_valid & ~rst),
                .match    (m[i][k]),
                .ready    (r[i][k])
            );
        end
    end
    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        fwd_hit = '0;
        fwd_sel = '0;
        blk = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (m[i][k]) begin
                    fwd_hit[i] = r[i][k];
                    fwd_sel[i] = r[i][k] ? NSTG'(1) << k : '0;
                    blk[i] = ~r[i][k];
                end
            end
        end
        stall = |blk;
    end
    assign dec_entry = '{
        valid:   dec_valid & (dec_dst_g | dec_dst_f),
        addr:    MAX_ADDR_W'(dec_dst_addr),
        to_g:    dec_dst_g,
        to_f:    dec_dst_f,
        rdy_stg: RDY_STG_W'(dec_rdy_stg)
    };
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < NSTG; k++) stg[k] <= '0;
        end else begin
            stg[0] <= stall ? '0 : dec_entry;
            for (int k = 1; k < NSTG; k++) stg[k] <= stg[k-1];
        end
    end
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [32:0] fwd_sum;
    assign fwd_sum = {1'b0, stat_fwd_cnt} + 33'($countones(fwd_hit));
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_stall_cyc <= '0;
            stat_fwd_cnt <= '0;
        end else begin
            if (stall && ~&stat_stall_cyc) stat_stall_cyc <= stat_stall_cyc + 32'd1;
            stat_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end
`endif
endmodule
